// File: rtl/rmii_rx_framer_if.sv
// rmii_rx_framer_if: RMII receive pins plus the framed dibit stream handed to the MAC filter
interface rmii_rx_framer_if #(
  parameter int CNT_W = 11
);
  logic crsdv;
  logic [1:0] rxd;
  logic axiov;
  logic [1:0] axiod;
  logic err;
  logic [CNT_W-1:0] frame_bytes;
  modport master (
    output crsdv, rxd,
    input  axiov, axiod, err, frame_bytes
  );
  modport slave (
    input  crsdv, rxd,
    output axiov, axiod, err, frame_bytes
  );
endinterface

// File: rtl/rmii_rx_framer.sv
// rmii_rx_framer: strips RMII preamble/SFD and re-emits each payload byte as MSB-first dibits
module rmii_rx_framer #(
  parameter int MIN_PREAMBLE = 8,
  parameter int CNT_W = 11
) (
  input logic clk,
  input logic rst,
  rmii_rx_framer_if.slave bus
);
  localparam int PW = $clog2(MIN_PREAMBLE + 1);
  localparam logic [PW-1:0] PMAX = PW'(MIN_PREAMBLE);
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;
  state_t state;
  logic [PW-1:0] cnt;
  logic [1:0] ph;
  logic [1:0] orem;
  logic [5:0] shreg;
  logic [5:0] obuf;
  logic [7:0] byte_in;
  logic [CNT_W-1:0] bcnt;
  logic load;
  // the last dibit of a byte bypasses shreg so the byte can load on the same edge
  assign load = state == DATA && bus.crsdv && ph == 2'd3;
  assign byte_in = {bus.rxd, shreg};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DROP;
      cnt <= '0;
      ph <= '0;
      shreg <= '0;
      bcnt <= '0;
      obuf <= '0;
      orem <= '0;
      bus.axiov <= 1'b0;
      bus.axiod <= 2'b00;
      bus.err <= 1'b0;
      bus.frame_bytes <= '0;
    end else begin
      bus.err <= 1'b0;
      case (state)
        IDLE:
          if (bus.crsdv && bus.rxd != 2'b00) begin
            state <= bus.rxd == 2'b01 ? PREAMBLE : DROP;
            bus.err <= bus.rxd != 2'b01;
            cnt <= PW'(1);
          end
        PREAMBLE:
          if (!bus.crsdv) begin
            state <= IDLE;
            bus.err <= 1'b1;
          end else if (bus.rxd == 2'b01) begin
            if (cnt != PMAX) cnt <= cnt + 1'b1;
          end else if (bus.rxd == 2'b11 && cnt >= PMAX) begin
            state <= DATA;
            ph <= '0;
            bcnt <= '0;
          end else begin
            state <= DROP;
            bus.err <= 1'b1;
          end
        DATA:
          if (!bus.crsdv) begin
            state <= IDLE;
            bus.frame_bytes <= bcnt;
            bus.err <= ph != 2'd0;
          end else begin
            ph <= ph + 2'd1;
            if (ph != 2'd3) shreg[{ph, 1'b0} +: 2] <= bus.rxd;
            else if (bcnt != '1) bcnt <= bcnt + 1'b1;
          end
        DROP:
          if (!bus.crsdv) state <= IDLE;
      endcase
      // the top dibit goes out immediately; the rest drain from obuf over three cycles
      if (load) begin
        obuf <= byte_in[5:0];
        orem <= 2'd3;
        bus.axiov <= 1'b1;
        bus.axiod <= byte_in[7:6];
      end else if (orem != 2'd0) begin
        orem <= orem - 2'd1;
        bus.axiov <= 1'b1;
        bus.axiod <= obuf[{orem - 2'd1, 1'b0} +: 2];
      end else begin
        bus.axiov <= 1'b0;
        bus.axiod <= 2'b00;
      end
    end
  end
endmodule

// File: tb/tb_rmii_rx_framer.sv
// tb_rmii_rx_framer: table of frame scenarios plus hand-written corner sequences, scoreboarded output
`timescale 1ns/1ps
module tb_rmii_rx_framer;
  localparam int CNT_W = 11;
  typedef struct {logic [1:0] d; int c;} exp_t;
  typedef struct {int pre; logic [1:0] sfd; int nb; int xd; bit acc; int err_at; int fb;} vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rmii_rx_framer_if #(.CNT_W(CNT_W)) bus();
  rmii_rx_framer #(.MIN_PREAMBLE(8), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  exp_t q[$];
  exp_t me;
  logic [7:0] bq[$];
  vec_t tbl[9];
  int ncmp = 0, nfail = 0, pc = 0, errs = 0, err_pc = -1, rises = 0, vcnt = 0;
  int sfd_pc, end_pc, fbm, z;
  bit en = 1'b0, pv = 1'b0;
  task automatic chk(input string n, input longint a, input longint e);
    ncmp++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, pc);
    end
  endtask
  always @(negedge clk) if (en) begin
    if (bus.err) begin
      errs++;
      err_pc = pc;
    end
    if (bus.axiov && !pv) rises++;
    pv = bus.axiov;
    if (bus.axiov) begin
      vcnt++;
      if (q.size() == 0) chk("unexpected_axiov", 1, 0);
      else begin
        me = q.pop_front();
        chk("axiod", bus.axiod, me.d);
        chk("axiov_cycle", pc, me.c);
      end
    end else chk("axiod_idle", bus.axiod, 0);
  end
  task automatic step(input logic c, input logic [1:0] d);
    bus.crsdv = c;
    bus.rxd = d;
    @(posedge clk);
    pc++;
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b, input int np);
    int p0;
    p0 = 0;
    for (int j = 0; j < 4; j++) begin
      step(1'b1, b[2*j +: 2]);
      if (j == 0) p0 = pc;
    end
    for (int j = 0; j < np; j++) q.push_back(exp_t'{b[7-2*j -: 2], p0 + 3 + j});
  endtask
  task automatic fill(input int n);
    bq.delete();
    repeat (n) bq.push_back(8'($urandom));
  endtask
  task automatic send_frame(input int pre, input logic [1:0] sfd, input int xd, input bit acc, input int gap);
    for (int i = 0; i < pre; i++) step(1'b1, 2'b01);
    step(1'b1, sfd);
    sfd_pc = pc;
    foreach (bq[b]) send_byte(bq[b], acc ? 4 : 0);
    for (int i = 0; i < xd; i++) step(1'b1, 2'($urandom_range(0, 3)));
    for (int g = 0; g < gap; g++) begin
      step(1'b0, 2'b00);
      if (g == 0) end_pc = pc;
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl = '{'{31, 2'b11, 4, 0, 1, 0, 4},
            '{8,  2'b11, 1, 0, 1, 0, 1},
            '{7,  2'b11, 2, 0, 0, 1, -1},
            '{5,  2'b11, 2, 0, 0, 1, -1},
            '{12, 2'b11, 3, 2, 1, 2, 3},
            '{9,  2'b11, 0, 0, 1, 0, 0},
            '{10, 2'b10, 1, 0, 0, 1, -1},
            '{8,  2'b11, 2, 1, 1, 2, 2},
            '{20, 2'b11, 6, 3, 1, 2, 6}};
    bus.crsdv = 1'b0;
    bus.rxd = 2'b00;
    repeat (3) step(1'b0, 2'b00);
    chk("rst_axiov", bus.axiov, 0);
    chk("rst_axiod", bus.axiod, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_frame_bytes", bus.frame_bytes, 0);
    rst = 1'b0;
    step(1'b0, 2'b00);
    en = 1'b1;
    fbm = 0;
    // good frame FE ED with a long preamble
    errs = 0; vcnt = 0;
    bq = '{8'hFE, 8'hED};
    send_frame(31, 2'b11, 0, 1'b1, 12);
    chk("fe_ed_valid_cycles", vcnt, 8);
    chk("fe_ed_err", errs, 0);
    chk("fe_ed_frame_bytes", bus.frame_bytes, 2);
    chk("fe_ed_drained", q.size(), 0);
    fbm = 2;
    for (int i = 0; i < 9; i++) begin
      errs = 0;
      fill(tbl[i].nb);
      send_frame(tbl[i].pre, tbl[i].sfd, tbl[i].xd, tbl[i].acc, 12);
      chk($sformatf("vec%0d_err_count", i), errs, tbl[i].err_at != 0 ? 1 : 0);
      if (tbl[i].err_at == 1) chk($sformatf("vec%0d_err_at_sfd", i), err_pc, sfd_pc);
      if (tbl[i].err_at == 2) chk($sformatf("vec%0d_err_at_end", i), err_pc, end_pc);
      if (tbl[i].fb >= 0) fbm = tbl[i].fb;
      chk($sformatf("vec%0d_frame_bytes", i), bus.frame_bytes, fbm);
      chk($sformatf("vec%0d_drained", i), q.size(), 0);
    end
    // rxd=00 with carrier in IDLE is ignored
    errs = 0;
    repeat (3) step(1'b1, 2'b00);
    fill(1);
    send_frame(8, 2'b11, 0, 1'b1, 12);
    chk("idle00_err", errs, 0);
    chk("idle00_frame_bytes", bus.frame_bytes, 1);
    // frame starting with 10 drops the whole carrier period
    errs = 0;
    step(1'b1, 2'b10);
    z = pc;
    fill(1);
    send_frame(9, 2'b11, 0, 1'b0, 12);
    chk("idle10_err", errs, 1);
    chk("idle10_err_at", err_pc, z);
    chk("idle10_frame_bytes", bus.frame_bytes, 1);
    // corrupt preamble followed by a would-be valid preamble in the same carrier
    errs = 0;
    bq.delete();
    send_frame(10, 2'b00, 0, 1'b0, 0);
    z = sfd_pc;
    fill(2);
    send_frame(20, 2'b11, 0, 1'b0, 12);
    chk("corrupt_err", errs, 1);
    chk("corrupt_err_at", err_pc, z);
    chk("corrupt_frame_bytes", bus.frame_bytes, 1);
    fill(2);
    send_frame(8, 2'b11, 0, 1'b1, 12);
    chk("after_corrupt_frame_bytes", bus.frame_bytes, 2);
    chk("after_corrupt_drained", q.size(), 0);
    // reset during byte 5 of a frame
    errs = 0;
    repeat (8) step(1'b1, 2'b01);
    step(1'b1, 2'b11);
    repeat (3) send_byte(8'($urandom), 4);
    send_byte(8'($urandom), 1);
    rst = 1'b1;
    step(1'b1, 2'($urandom_range(0, 3)));
    rst = 1'b0;
    chk("axiov_after_rst", bus.axiov, 0);
    repeat (3) step(1'b1, 2'b11);
    repeat (4) step(1'b1, 2'($urandom_range(0, 3)));
    repeat (12) step(1'b0, 2'b00);
    chk("rst_mid_err", errs, 0);
    chk("rst_mid_frame_bytes", bus.frame_bytes, 0);
    chk("rst_mid_drained", q.size(), 0);
    fill(3);
    send_frame(8, 2'b11, 0, 1'b1, 12);
    chk("after_rst_frame_bytes", bus.frame_bytes, 3);
    chk("after_rst_drained", q.size(), 0);
    // back-to-back frames with a single idle cycle
    errs = 0; rises = 0;
    fill(3);
    send_frame(8, 2'b11, 0, 1'b1, 1);
    chk("b2b_first_frame_bytes", bus.frame_bytes, 3);
    fill(2);
    send_frame(8, 2'b11, 0, 1'b1, 12);
    chk("b2b_second_frame_bytes", bus.frame_bytes, 2);
    chk("b2b_axiov_rises", rises, 2);
    chk("b2b_err", errs, 0);
    chk("b2b_drained", q.size(), 0);
    // byte counter saturates
    errs = 0;
    fill(2050);
    send_frame(8, 2'b11, 0, 1'b1, 12);
    chk("sat_frame_bytes", bus.frame_bytes, 2047);
    chk("sat_err", errs, 0);
    chk("sat_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
